// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU control decoder and alu_exec_unit:
//   - ALUop encodings (ALU_ADD ... ALU_PASSA)
//   - execution FSM state encoding (IDLE, SHIFT, DONE)
//   - is_shift(): true for the three shift opcodes
//   Any opcode not listed here executes as ALU_ADD.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_AND   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SUB   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1110;
    localparam logic [3:0] ALU_PASSA = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter
//   Combinational shifter used by alu_exec_unit.
//   Build option ALU_BARREL_SHIFT_EN:
//     defined   - full barrel shift of din by shamt
//     undefined - single-position step (shamt is ignored); the caller
//                 iterates it once per cycle
//   Ports:
//     op    in  [3:0]          ALU_SLL / ALU_SRL / ALU_SRA (others pass din)
//     din   in  [WIDTH-1:0]    value to shift
//     shamt in  [SHAMT_W-1:0]  shift distance (barrel build only)
//     dout  out [WIDTH-1:0]    shifted value
module alu_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   dout
);
    import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
    logic signed [WIDTH-1:0] din_s;
    logic signed [WIDTH-1:0] sra_s;

    assign din_s = din;
    assign sra_s = din_s >>> shamt;

    always_comb begin
        dout = din;
        case (op)
            ALU_SLL: dout = din << shamt;
            ALU_SRL: dout = din >> shamt;
            ALU_SRA: dout = sra_s;
            default: dout = din;
        endcase
    end
`else
    // The iterative build shifts exactly one position per call.
    logic unused_shamt;
    assign unused_shamt = ^shamt;

    always_comb begin
        dout = din;
        case (op)
            ALU_SLL: dout = {din[WIDTH-2:0], 1'b0};
            ALU_SRL: dout = {1'b0, din[WIDTH-1:1]};
            ALU_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Multi-cycle ALU with a start/busy/done handshake.
//   Logic, arithmetic and compare ops finish one cycle after start; shifts
//   step one bit per cycle (shamt + 1 cycles) unless ALU_BARREL_SHIFT_EN is
//   defined, in which case every op finishes one cycle after start.
//   Ports:
//     clk     in   system clock, rising edge
//     reset   in   asynchronous active-high reset
//     start   in   op request, sampled only while idle
//     ALUop   in   [3:0] opcode (alu_pkg encodings)
//     a, b    in   [WIDTH-1:0] operands; b[SHAMT_W-1:0] is the shift amount
//     busy    out  op in progress (includes the done cycle)
//     done    out  one-cycle pulse, result/zero/ovf valid
//     result  out  [WIDTH-1:0] registered result, held until the next done
//     zero    out  result == 0
//     ovf     out  signed overflow of ADD/SUB, 0 for other ops
module alu_exec_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUop,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf
);
    import alu_pkg::*;

    alu_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

`ifndef ALU_BARREL_SHIFT_EN
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
`endif

    // Single-cycle arithmetic/logic path, driven straight from the inputs
    // so the result can be registered on the accepting edge.
    logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
    logic                    add_ovf, sub_ovf;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;

    assign a_s    = a;
    assign b_s    = b;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    // Same-sign operands producing a different-sign sum, or (for SUB)
    // opposite-sign operands where the difference loses a's sign.
    assign add_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1]  != a_s[WIDTH-1]);
    assign sub_ovf = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_s[WIDTH-1]);

    always_comb begin
        alu_res = sum_s;
        alu_ovf = add_ovf;
        case (ALUop)
            ALU_ADD:   begin alu_res = sum_s;  alu_ovf = add_ovf; end
            ALU_AND:   begin alu_res = a & b;  alu_ovf = 1'b0;    end
            ALU_OR:    begin alu_res = a | b;  alu_ovf = 1'b0;    end
            ALU_XOR:   begin alu_res = a ^ b;  alu_ovf = 1'b0;    end
            ALU_SLT:   begin
                alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                alu_ovf = 1'b0;
            end
            ALU_SUB:   begin alu_res = diff_s; alu_ovf = sub_ovf; end
            ALU_PASSA: begin alu_res = a;      alu_ovf = 1'b0;    end
            default:   begin alu_res = sum_s;  alu_ovf = add_ovf; end
        endcase
    end

    // Shifter: the barrel build shifts the live inputs in one go, the
    // iterative build steps the captured shift register once per cycle.
    logic [3:0]         sh_op;
    logic [WIDTH-1:0]   sh_din;
    logic [SHAMT_W-1:0] sh_amt;
    logic [WIDTH-1:0]   sh_out;

`ifdef ALU_BARREL_SHIFT_EN
    assign sh_op  = ALUop;
    assign sh_din = a;
    assign sh_amt = b[SHAMT_W-1:0];
`else
    assign sh_op  = op_q;
    assign sh_din = sreg_q;
    assign sh_amt = cnt_q;
`endif

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .op    (sh_op),
        .din   (sh_din),
        .shamt (sh_amt),
        .dout  (sh_out)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
`ifndef ALU_BARREL_SHIFT_EN
        op_d     = op_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift(ALUop)) begin
`ifdef ALU_BARREL_SHIFT_EN
                        result_d = sh_out;
                        ovf_d    = 1'b0;
                        state_d  = DONE;
`else
                        op_d   = ALUop;
                        sreg_d = a;
                        cnt_d  = b[SHAMT_W-1:0];
                        // A zero shift amount needs no iteration.
                        if (b[SHAMT_W-1:0] == '0) begin
                            result_d = a;
                            ovf_d    = 1'b0;
                            state_d  = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
`endif
                    end else begin
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
                state_d = IDLE;
`else
                sreg_d = sh_out;
                cnt_d  = cnt_q - CNT_ONE;
                // Last step: publish the shifted value directly.
                if (cnt_q == CNT_ONE) begin
                    result_d = sh_out;
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            op_q     <= ALU_ADD;
            sreg_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`ifndef ALU_BARREL_SHIFT_EN
            op_q     <= op_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle ALU datapath that consumes the 4-bit ALUop code driven by the ALU control decoder, and computes on two WIDTH-bit operands.
- Logic, arithmetic and compare ops complete one cycle after start.
- Shifts iterate one bit position per cycle under a small FSM.
- A start/busy/done handshake lets the processor control unit stall until the result is valid.

Parameters:
WIDTH, 16, operand and result width in bits
SHAMT_W, 4, shift-amount width; taken from b[SHAMT_W-1:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  operation request; sampled only in IDLE
ALUop  input  4  operation code from ALU control decoder
a  input  WIDTH  operand A (shift source for shifts)
b  input  WIDTH  operand B (shift amount in low SHAMT_W bits for shifts)
busy  output  1  high while an accepted operation is in progress
done  output  1  one-cycle pulse; result, zero and ovf valid in that cycle
result  output  WIDTH  registered result; held until the next done
zero  output  1  registered; result == 0
ovf  output  1  registered two's-complement overflow; ADD/SUB only, else 0

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset values: state = IDLE, busy = 0, done = 0, result = 0, zero = 1, ovf = 0.
- Op encoding (package constants):
  - 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SLT (signed; result 1 or 0), 0111 SUB (a-b)
  - 0101 SLL, 0110 SRL, 1110 SRA
  - 1111 PASSA (result = a)
  - All other codes execute as ADD.
- Operands and ALUop are captured on the accepting edge; later input changes do not affect the op in flight.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start with a non-shift op: result is computed and registered on that edge, then go to DONE.
  - On start with a shift op: capture a into the shift register and b[SHAMT_W-1:0] into a counter.
    - Counter 0: go to DONE with result = a.
    - Counter nonzero: go to SHIFT.
  - busy = 0 in IDLE.
- SHIFT:
  - Each cycle, shift one position and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the MSB.
  - When the counter reaches 0, latch result and go to DONE.
  - busy = 1.
- DONE: done = 1 and busy = 1 for exactly one cycle, then return to IDLE.
- Latency from the start edge to done high:
  - non-shift ops: 1 cycle
  - shifts: shamt + 1 cycles
- start is ignored while busy; no queueing.
- start in the same cycle that done is high is also ignored.
- ovf:
  - ADD: set when sign(a) == sign(b) and sign(result) != sign(a).
  - SUB: set when sign(a) != sign(b) and sign(result) != sign(a).
  - Result wraps modulo 2^WIDTH.
- Reset asserted mid-operation aborts it immediately; no done pulse is produced.

Optional Feature:
ALU_BARREL_SHIFT_EN
- Defined: shifts are combinational barrel shifts. SHIFT state is unused; every op has 1-cycle latency.
- Undefined: iterative shifting as described under Behaviour.
- Handshake is identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - ALUop localparams (ALU_ADD ... ALU_PASSA)
  - FSM state encoding (IDLE, SHIFT, DONE)
  - function is_shift(op)
- ALU control decoder and this block share alu_pkg.
- One sub-module: alu_shifter, a one-step or barrel shifter depending on ALU_BARREL_SHIFT_EN. All other ops stay inline.

Test Plan:
1. Reset then ADD: a=0x7FFF, b=0x0001, start for 1 cycle -> busy=1 next cycle, done pulse 1 cycle after start, result=0x8000, ovf=1, zero=0.
2. SUB with equal operands: a=b=0x1234 -> result=0x0000, zero=1, ovf=0. Then SLT with a=0xFFFF, b=0x0001 -> result=0x0001.
3. SRA: a=0x8000, b=0x0004 -> busy held for 5 cycles, done on the 5th cycle after start, result=0xF800. With ALU_BARREL_SHIFT_EN, the same result 1 cycle after start.
4. SLL shamt=0: a=0x00A5, b=0x0000 -> done 1 cycle after start, result=0x00A5.
5. Busy protection: start SRL a=0xFFFF, b=0x0008; re-pulse start with ADD during SHIFT and in the done cycle -> single done, result=0x00FF, no second operation.
6. Reset mid-shift: SLL a=0x0001, b=0x000F; assert reset after 3 cycles -> immediately busy=0, done=0, result=0, zero=1. After release, ALUop=1001 (unused code) with a=2, b=3 -> result=0x0005.
